// File: rtl/truth_table_sweeper_pkg.sv
// Purpose: shared types and width helpers for the truth-table sweeper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tt_pkg;

    // FSM encoding; the enum literals double as the 2-bit state constants.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } tt_state_t;

    // Minterm-mask width for an n-input function: one bit per input vector.
    function automatic int tt_w(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Purpose: bundles the sweeper's request, function-under-test and result signals.
// Latency: n/a (wiring only).
// Backpressure: none; start is simply ignored while a sweep runs.
// Ports: master = harness/driver side, slave = sweeper side.
interface truth_table_sweeper_if #(
    parameter int N_IN = 3
);
    localparam int TT_W = tt_pkg::tt_w(N_IN);

    logic              start;
    logic [TT_W-1:0]   expected;
    logic              resp_in;
    logic [N_IN-1:0]   vec_out;
    logic              busy;
    logic              done;
    logic [TT_W-1:0]   minterms;
    logic [N_IN:0]     ones_count;
    logic              pass;

    modport master (
        output start, expected, resp_in,
        input  vec_out, busy, done, minterms, ones_count, pass
    );

    modport slave (
        input  start, expected, resp_in,
        output vec_out, busy, done, minterms, ones_count, pass
    );
endinterface

// File: rtl/truth_table_sweeper_popcount.sv
// Purpose: combinational population count of a W-bit vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: i_vec (W bits in), o_cnt (CW-bit count out, CW must hold W).
module tt_popcount #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic [W-1:0]  i_vec,
    output logic [CW-1:0] o_cnt
);
    logic [CW-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < W; i++) begin
            w_sum = w_sum + CW'(i_vec[i]);
        end
    end

    assign o_cnt = w_sum;
endmodule

// File: rtl/truth_table_sweeper.sv
// Purpose: sweeps all 2**N_IN input vectors through a boolean function and builds its minterm mask.
// Latency: done 2**N_IN*(SETTLE+1)+1 edges after the start edge.
// Backpressure: none; start outside IDLE is dropped, no queuing.
// Ports: clk, rst_n (sync, active-low), tt_bus (slave modport: start/expected/resp_in in,
//        vec_out/busy/done/minterms/ones_count/pass out).
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    truth_table_sweeper_if.slave       tt_bus
);
    localparam int TT_W = tt_w(N_IN);
    localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    tt_state_t         r_state;
    logic [CW-1:0]     r_wait;
    logic [N_IN-1:0]   r_vec;
    logic [TT_W-1:0]   r_minterms;
    logic [TT_W-1:0]   r_expected;
    logic              r_busy;
    logic              r_done;
    logic [N_IN:0]     r_ones;
    logic              r_pass;
    logic [N_IN:0]     w_ones;

    // Counts the live mask; it is only latched in FINISH, after the last sample has landed.
    tt_popcount #(
        .W  (TT_W),
        .CW (N_IN + 1)
    ) u_popcount (
        .i_vec (r_minterms),
        .o_cnt (w_ones)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wait     <= '0;
            r_vec      <= '0;
            r_minterms <= '0;
            r_expected <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ones     <= '0;
            r_pass     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tt_bus.start) begin
                        r_expected <= tt_bus.expected;
                        r_minterms <= '0;
                        r_ones     <= '0;
                        r_pass     <= 1'b0;
                        r_vec      <= '0;
                        r_wait     <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    r_wait <= r_wait + CW'(1);
                    if (r_wait == CW'(SETTLE - 1)) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    r_minterms[r_vec] <= tt_bus.resp_in;
                    // Terminal compare stops the vector at all-ones so it never wraps.
                    if (r_vec == '1) begin
                        r_state <= ST_FINISH;
                    end else begin
                        r_vec   <= r_vec + N_IN'(1);
                        r_wait  <= '0;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_pass  <= (r_minterms == r_expected);
                    r_ones  <= w_ones;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tt_bus.vec_out    = r_vec;
    assign tt_bus.busy       = r_busy;
    assign tt_bus.done       = r_done;
    assign tt_bus.minterms   = r_minterms;
    assign tt_bus.ones_count = r_ones;
    assign tt_bus.pass       = r_pass;
endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential truth-table sweeper that sits directly upstream and downstream of a single-output combinational boolean function under test. On `start` it drives every input vector `0 … 2^N_IN−1` in ascending order. After each vector it waits a programmable settle time, then samples the function's 1-bit response into a minterm mask. When the sweep finishes it reports the mask, its popcount and a pass/fail comparison against an expected mask. It is the standard harness stage for the boolean-algebra exercises in the data-types/operators area.

## Interface
Parameters:
- `N_IN`, default 3: number of function inputs; legal range 1–8.
- `SETTLE`, default 1: cycles each vector is held before sampling; minimum 1.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `start`, input, 1: sweep request; sampled only in IDLE.
- `expected`, input, `2**N_IN`: golden minterm mask; sampled on the cycle `start` is accepted.
- `resp_in`, input, 1: output `y` of the function under test.
- `vec_out`, output, `N_IN`: input vector driven to the function (`x`).
- `busy`, output, 1: high while a sweep is in progress.
- `done`, output, 1: one-cycle pulse at the end of a sweep.
- `minterms`, output, `2**N_IN`: bit k = response sampled for vector k.
- `ones_count`, output, `N_IN+1`: popcount of `minterms`.
- `pass`, output, 1: `minterms == expected`.

## Operation
Reset (`rst_n`=0 at a clock edge) forces all outputs to 0 and the state to IDLE. This applies equally in the middle of a sweep: the sweep is abandoned and no `done` is produced.

FSM states and transitions:
- **IDLE**
  - If `start`=1: capture `expected`, clear `minterms`, set `vec_out`=0, clear the wait counter, set `busy`=1, go to SETTLE.
  - Otherwise: hold all outputs.
- **SETTLE**
  - Increment the wait counter each cycle.
  - When the counter reaches `SETTLE−1`, go to SAMPLE.
- **SAMPLE**
  - `minterms[vec_out] <= resp_in`.
  - If `vec_out == 2**N_IN−1`: go to FINISH.
  - Otherwise: increment `vec_out`, clear the wait counter, go to SETTLE.
- **FINISH**
  - `done`=1 for exactly this cycle; `busy`=0.
  - `pass` and `ones_count` are valid in this cycle, computed over the final mask including the last sample.
  - Go to IDLE.

Further rules:
- `start` while not in IDLE is ignored; there is no queuing.
- `start` held high continuously starts a new sweep on the cycle after FINISH.
- `minterms`, `pass` and `ones_count` hold their values in IDLE until the next accepted `start`.
- `vec_out` holds its last value (`2**N_IN−1`) after a sweep.
- `vec_out` never wraps during a sweep; the terminal compare stops it.
- `ones_count` is `N_IN+1` bits wide, so the all-ones mask (`2**N_IN` set bits) does not overflow.
- `expected` changes after acceptance have no effect on the current sweep.

## Timing
- Start accepted at edge E0.
- Vector k is driven from edge `E0 + k·(SETTLE+1)`.
- Vector k is sampled at edge `E0 + k·(SETTLE+1) + SETTLE + 1`.
- `done` is high in the cycle following edge `E0 + 2**N_IN·(SETTLE+1) + 1`.
  - N_IN=3, SETTLE=1: edge E17.
  - N_IN=2, SETTLE=3: edge E17.
- `busy` rises the cycle after E0 and falls in the same cycle `done` rises.
- `pass` and `ones_count` are registered and become valid in the same cycle as `done`.
- `resp_in` must be stable within SETTLE cycles of a `vec_out` change. The block does not synchronise `resp_in`; it must be from the same clock domain or purely combinational from `vec_out`.

## Structure
- Shared package `tt_pkg` holds:
  - state encoding constants `ST_IDLE`, `ST_SETTLE`, `ST_SAMPLE`, `ST_FINISH` (2-bit);
  - the width helper `TT_W = 2**N_IN` convention.
- One natural sub-module: `tt_popcount`, a parameterised-width combinational popcount feeding the `ones_count` register.
- Everything else lives in the top module: FSM, wait counter, vector counter, mask register, compare.

## Test plan
- AND3 (`resp_in = &vec_out`), `expected`=8'h80, defaults → `minterms`=8'h80, `ones_count`=1, `pass`=1, `done` at E17.
- XOR3 parity, `expected`=8'h96 → `minterms`=8'h96, `ones_count`=4, `pass`=1.
- OR3 with `expected`=8'h96 → `minterms`=8'hFE, `ones_count`=7, `pass`=0; constant-1 function → 8'hFF, `ones_count`=8.
- N_IN=2, SETTLE=3, function `x[0]&~x[1]`:
  - `vec_out` changes every 4 cycles;
  - `minterms`=4'h2;
  - `done` at E17.
- `start` pulsed at E5 during a sweep → ignored, single `done` at E17. `start` held high → second sweep's `busy` begins the cycle after `done`.
- `rst_n`=0 at E7 mid-sweep → all outputs 0 the following cycle, state IDLE, no `done`; a fresh `start` afterwards completes normally.
